// File: rtl/pipelined_cla_addsub.sv
// Pipelined signed adder/subtractor built from carry-lookahead chunks.
// One chunk per stage; operands skew forward, result chunks deskew.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int C = WIDTH / STAGES;

    // 4-bit lookahead groups; each bit's carry comes from the group-entry carry.
    function automatic logic [C:0] cla_chunk(
        input logic [C-1:0] x,
        input logic [C-1:0] y,
        input logic         ci
    );
        logic [C:0]   c;
        logic [C-1:0] g;
        logic [C-1:0] p;
        logic         gg;
        logic         pp;
        logic         cg;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        gg   = 1'b0;
        pp   = 1'b1;
        cg   = ci;
        for (int i = 0; i < C; i++) begin
            if (i % 4 == 0) begin
                gg = 1'b0;
                pp = 1'b1;
                cg = c[i];
            end
            gg     = g[i] | (p[i] & gg);
            pp     = pp & p[i];
            c[i+1] = gg | (pp & cg);
        end
        return {c[C], p ^ c[C-1:0]};
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_bp;
    logic             w_cp;
    logic [C-1:0]     w_fx;
    logic [C-1:0]     w_fy;
    logic             w_fc;
    logic             w_fv;
    logic             w_fsat;
    logic [C:0]       w_fs;
    logic [WIDTH-1:0] w_full;
    logic             w_cmsb;
    logic             w_ov;
    logic [WIDTH-1:0] w_out;

    logic             r_ovld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_adv    = out_ready || !r_ovld;
    assign in_ready = w_adv;
    assign w_bp     = sub ? ~b : b;
    assign w_cp     = sub ? ~cin : cin;

    generate
        if (STAGES == 1) begin : g_one
            assign w_fx   = a;
            assign w_fy   = w_bp;
            assign w_fc   = w_cp;
            assign w_fv   = in_valid;
            assign w_fsat = sat;
            assign w_full = w_fs[C-1:0];
        end else begin : g_pipe
            for (genvar k = 0; k < STAGES - 1; k++) begin : g_lv
                localparam int RW = (k + 1) * C;
                localparam int OW = WIDTH - RW;

                logic [C-1:0]  w_x;
                logic [C-1:0]  w_y;
                logic          w_ci;
                logic          w_vi;
                logic          w_si;
                logic [OW-1:0] w_an;
                logic [OW-1:0] w_bn;
                logic [RW-1:0] w_rn;
                logic [C:0]    w_s;

                logic          r_v;
                logic          r_c;
                logic          r_sat;
                logic [RW-1:0] r_res;
                logic [OW-1:0] r_a;
                logic [OW-1:0] r_b;

                if (k == 0) begin : g_in
                    assign w_x  = a[C-1:0];
                    assign w_y  = w_bp[C-1:0];
                    assign w_ci = w_cp;
                    assign w_vi = in_valid;
                    assign w_si = sat;
                    assign w_an = a[WIDTH-1:C];
                    assign w_bn = w_bp[WIDTH-1:C];
                    assign w_rn = w_s[C-1:0];
                end else begin : g_mid
                    assign w_x  = g_lv[k-1].r_a[C-1:0];
                    assign w_y  = g_lv[k-1].r_b[C-1:0];
                    assign w_ci = g_lv[k-1].r_c;
                    assign w_vi = g_lv[k-1].r_v;
                    assign w_si = g_lv[k-1].r_sat;
                    assign w_an = g_lv[k-1].r_a[WIDTH-k*C-1:C];
                    assign w_bn = g_lv[k-1].r_b[WIDTH-k*C-1:C];
                    assign w_rn = {w_s[C-1:0], g_lv[k-1].r_res};
                end

                assign w_s = cla_chunk(w_x, w_y, w_ci);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_v   <= 1'b0;
                        r_c   <= 1'b0;
                        r_sat <= 1'b0;
                        r_res <= '0;
                        r_a   <= '0;
                        r_b   <= '0;
                    end else if (w_adv) begin
                        r_v   <= w_vi;
                        r_c   <= w_s[C];
                        r_sat <= w_si;
                        r_res <= w_rn;
                        r_a   <= w_an;
                        r_b   <= w_bn;
                    end
                end
            end

            assign w_fx   = g_lv[STAGES-2].r_a;
            assign w_fy   = g_lv[STAGES-2].r_b;
            assign w_fc   = g_lv[STAGES-2].r_c;
            assign w_fv   = g_lv[STAGES-2].r_v;
            assign w_fsat = g_lv[STAGES-2].r_sat;
            assign w_full = {w_fs[C-1:0], g_lv[STAGES-2].r_res};
        end
    endgenerate

    assign w_fs   = cla_chunk(w_fx, w_fy, w_fc);
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign w_cmsb = w_full[WIDTH-1] ^ w_fx[C-1] ^ w_fy[C-1];
    assign w_ov   = w_cmsb ^ w_fs[C];
    assign w_out  = (w_fsat && w_ov)
                  ? (w_fx[C-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}})
                  : w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovld <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_ovld <= w_fv;
            r_sum  <= w_out;
            r_cout <= w_fs[C];
            r_ovf  <= w_ov;
        end
    end

    assign out_valid = r_ovld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

- Parametrised, pipelined signed adder/subtractor built from carry-lookahead segments.
- Successor to the 32-bit combinational carry-lookahead adder: adds selectable width and pipeline depth, per-operation add/subtract and saturation, and a valid/ready handshake with backpressure.
- Sits in the datapath between operand registers and downstream consumers (accumulators, ALU result mux). Sustains one operation per cycle when not stalled.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a multiple of STAGES.
- STAGES, 4, pipeline segments. Each segment adds WIDTH/STAGES bits; STAGES = 1 gives a single registered stage.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- sat  input  1  1: saturate on signed overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  signed result.
- cout  output  1  raw carry out of the MSB of the internal adder.
- overflow  output  1  signed overflow of the unsaturated result.

## Operation
- Internal operation is a + b' + c', where:
  - b' = b when sub = 0, b' = ~b when sub = 1.
  - c' = cin when sub = 0, c' = !cin when sub = 1.
- Segments: chunk k covers bits [k·C +: C], with C = WIDTH/STAGES.
  - Inside each chunk, use 4-bit carry-lookahead groups (group generate/propagate), rippled between groups.
  - Stage k adds chunk k using the registered carry from stage k−1. Stage 0 uses c'.
- Skew and deskew:
  - Operand chunks not yet consumed travel with the operation in skew registers.
  - Completed result chunks travel forward in deskew registers, so all chunks of one operation emerge together.
  - sub, sat, a[MSB] and b'[MSB] also travel with the operation.
- overflow = carry into MSB XOR carry out of MSB. cout = carry out of MSB.
- Saturation: if sat = 1 and overflow = 1, sum is forced to the sign of a:
  - a[MSB] = 0 → 0111…1 (max positive).
  - a[MSB] = 1 → 1000…0 (min negative).
  - overflow still reads 1; cout is unaffected.
  - If sat = 0, sum wraps modulo 2^WIDTH.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Global stall: in_ready = out_ready || !out_valid.
  - When stalled (out_valid && !out_ready), every stage register, valid bit and output holds.
  - Inputs are ignored when in_ready = 0.
- Bubbles: when in_valid = 0 on an accepted cycle, an invalid bubble enters stage 0. Bubbles advance like data; no bubble collapsing.
- Operations complete in issue order; none are dropped or duplicated.

## Timing
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. after exactly STAGES accepting edges, when no stall occurs.
- Stalled cycles add to latency one-for-one.
- Throughput: 1 operation/cycle while out_ready = 1.
- Reset (rst_n low, asynchronous):
  - All valid bits clear immediately.
  - out_valid = 0, sum = 0, cout = 0, overflow = 0.
  - in_ready = 1 (it follows from out_valid = 0).
  - All in-flight operations are discarded, including those in progress when reset asserts mid-operation.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and required at full throughput.
- sum, cout and overflow are registered outputs; they change only on accepting edges or reset.
- Outputs while out_valid = 0 are don't-care, except immediately after reset, when they are 0.

## Test plan
- Add overflow wrap, WIDTH=32, STAGES=4: a=0x7FFFFFFF, b=1, cin=0, sub=0, sat=0 → after 4 cycles sum=0x80000000, overflow=1, cout=0.
- Subtract with saturation: a=0x80000000, b=1, sub=1, sat=1 → sum=0x80000000, overflow=1. Same operands with sat=0 → sum=0x7FFFFFFF, overflow=1.
- Back-to-back stream: issue 52−31, 152+2539, −495955+(−4548), −451+4498 on consecutive cycles with out_ready=1 → results 21, 2691, −500503, 4047 on 4 consecutive cycles starting at cycle 4, all overflow=0.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles → in_ready=0, outputs and order held; on release, results resume with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight → out_valid=0 and sum=0 immediately; after release, no stale result ever appears.
- Carry chain across segments, WIDTH=16, STAGES=1 and WIDTH=16, STAGES=4: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, overflow=0, at latency 1 and 4 respectively.
